// File: rtl/ir_tx_pkg.sv
// Shared types and constants for the NEC IR transmitter: FSM states, register map
// and protocol timing expressed in NEC base units.
package ir_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark
  } tx_state_e;

  localparam logic [3:0] AddrData = 4'd0;
  localparam logic [3:0] AddrCtrl = 4'd1;

  localparam int unsigned CtrlStart   = 0;
  localparam int unsigned CtrlRepeat  = 1;
  localparam int unsigned CtrlClrDone = 2;

  localparam logic [4:0] UnitsLeadMark   = 5'd16;
  localparam logic [4:0] UnitsLeadSpace  = 5'd8;
  localparam logic [4:0] UnitsRepeatSpc  = 5'd4;
  localparam logic [4:0] UnitsShort      = 5'd1;
  localparam logic [4:0] UnitsLong       = 5'd3;

  function automatic logic is_mark(tx_state_e s);
    return (s == StLeadMark) || (s == StBitMark) || (s == StStopMark);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// 38 kHz carrier source: a period counter restarted on each mark entry, high for the
// first CARRIER_HIGH cycles of every CARRIER_DIV-cycle period while enabled.
module ir_carrier_gen #(
  parameter int unsigned CARRIER_DIV  = 2632,
  parameter int unsigned CARRIER_HIGH = 877
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_carrier
);

  localparam int unsigned CntW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= (r_cnt == CntW'(CARRIER_DIV - 1)) ? '0 : r_cnt + CntW'(1);
    end
  end

  assign o_carrier = i_enable && (r_cnt < CntW'(CARRIER_HIGH));

endmodule

// File: rtl/ir_tx_avalon.sv
// NEC IR transmitter with an Avalon-MM slave: DATA/CTRL registers, frame FSM timed in
// whole base units, and a carrier-modulated LED drive.
module ir_tx_avalon
  import ir_tx_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES  = 56250,
  parameter int unsigned CARRIER_DIV  = 2632,
  parameter int unsigned CARRIER_HIGH = 877
) (
  input  logic        csi_clk,
  input  logic        csi_reset_n,
  input  logic        avs_chipselect,
  input  logic [3:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        coe_IRDA_TXD,
  output logic        coe_tx_env,
  output logic        coe_busy
);

  localparam int unsigned UnitW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  tx_state_e        r_state, w_state_d;
  logic [UnitW-1:0] r_unit_cnt;
  logic [4:0]       r_unit_num, w_dur, r_bit_idx;
  logic [31:0]      r_data, r_shift;
  logic             r_repeat, r_done;
  logic             w_wr_data, w_wr_ctrl, w_start, w_clr_done;
  logic             w_unit_last, w_state_end, w_state_chg, w_mark_entry, w_carrier;

  assign w_wr_data  = avs_chipselect && avs_write && (avs_address == AddrData);
  assign w_wr_ctrl  = avs_chipselect && avs_write && (avs_address == AddrCtrl);
  assign w_start    = w_wr_ctrl && avs_writedata[CtrlStart];
  assign w_clr_done = w_wr_ctrl && avs_writedata[CtrlClrDone];

  always_comb begin
    w_dur = UnitsShort;
    unique case (r_state)
      StLeadMark:  w_dur = UnitsLeadMark;
      StLeadSpace: w_dur = r_repeat ? UnitsRepeatSpc : UnitsLeadSpace;
      StBitSpace:  w_dur = r_shift[0] ? UnitsLong : UnitsShort;
      default:     w_dur = UnitsShort;
    endcase
  end

  assign w_unit_last = (r_unit_cnt == UnitW'(UNIT_CYCLES - 1));
  assign w_state_end = w_unit_last && (r_unit_num == w_dur - 5'd1);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:      if (w_start) w_state_d = StLeadMark;
      StLeadMark:  if (w_state_end) w_state_d = StLeadSpace;
      StLeadSpace: if (w_state_end) w_state_d = r_repeat ? StStopMark : StBitMark;
      StBitMark:   if (w_state_end) w_state_d = StBitSpace;
      StBitSpace:  if (w_state_end) w_state_d = (r_bit_idx == 5'd31) ? StStopMark : StBitMark;
      StStopMark:  if (w_state_end) w_state_d = StIdle;
      default:     w_state_d = StIdle;
    endcase
  end

  assign w_state_chg  = (w_state_d != r_state);
  assign w_mark_entry = w_state_chg && is_mark(w_state_d);

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      r_state    <= StIdle;
      r_unit_cnt <= '0;
      r_unit_num <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_repeat   <= 1'b0;
      r_data     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      // Every state entry restarts the unit timer so durations stay whole units.
      if (w_state_chg || (r_state == StIdle)) begin
        r_unit_cnt <= '0;
        r_unit_num <= '0;
      end else if (w_unit_last) begin
        r_unit_cnt <= '0;
        r_unit_num <= r_unit_num + 5'd1;
      end else begin
        r_unit_cnt <= r_unit_cnt + UnitW'(1);
      end
      if (r_state == StIdle && w_start) begin
        r_shift   <= r_data;
        r_repeat  <= avs_writedata[CtrlRepeat];
        r_bit_idx <= '0;
      end else if (r_state == StBitSpace && w_state_end) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= r_bit_idx + 5'd1;
      end
      if (w_wr_data) r_data <= avs_writedata;
      if (r_state == StStopMark && w_state_end) begin
        r_done <= 1'b1;
      end else if (w_clr_done) begin
        r_done <= 1'b0;
      end
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      avs_readdata <= '0;
    end else if (avs_chipselect && avs_read) begin
      case (avs_address)
        AddrData: avs_readdata <= r_data;
        AddrCtrl: avs_readdata <= {29'b0, r_done, coe_busy, 1'b0};
        default:  avs_readdata <= '0;
      endcase
    end
  end

  ir_carrier_gen #(
    .CARRIER_DIV  (CARRIER_DIV),
    .CARRIER_HIGH (CARRIER_HIGH)
  ) u_carrier (
    .i_clk     (csi_clk),
    .i_rst_n   (csi_reset_n),
    .i_enable  (coe_tx_env),
    .i_restart (w_mark_entry),
    .o_carrier (w_carrier)
  );

  assign coe_tx_env   = is_mark(r_state);
  assign coe_busy     = (r_state != StIdle);
  assign coe_IRDA_TXD = coe_tx_env && w_carrier;

endmodule

// File: doc/ir_tx_avalon.md
IR_TX_AVALON -- requirements
Module: ir_tx_avalon

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 56250, giving csi_clk cycles per 562.5 us NEC base unit at 100 MHz.
REQ-002 SHALL have parameter CARRIER_DIV, default 2632, giving csi_clk cycles per 38 kHz carrier period.
REQ-003 SHALL have parameter CARRIER_HIGH, default 877, giving carrier high cycles per period (~1/3 duty).
REQ-004 csi_clk  in  1  system clock, 100 MHz.
REQ-005 csi_reset_n  in  1  reset; asynchronous, active-low.
REQ-006 avs_chipselect  in  1  Avalon-MM slave select.
REQ-007 avs_address  in  4  register address; 0 = DATA, 1 = CTRL/STATUS, others reserved.
REQ-008 avs_read / avs_write  in  1 each  Avalon read / write strobes.
REQ-009 avs_writedata  in  32  write data.
REQ-010 avs_readdata  out  32  registered read data.
REQ-011 coe_IRDA_TXD  out  1  modulated IR LED drive, active-high.
REQ-012 coe_tx_env  out  1  unmodulated envelope (mark = 1), for debug.
REQ-013 coe_busy  out  1  frame in progress.

Function
REQ-014 A write to addr 0 with chipselect SHALL load DATA[31:0]; a write to DATA while busy SHALL NOT alter the frame in flight.
REQ-015 A write to addr 1: bit0 = START, bit1 = REPEAT (send repeat code instead of data frame), bit2 = CLR_DONE; all self-clearing strobes.
REQ-016 Reads SHALL have 1-cycle latency: addr 0 -> DATA; addr 1 -> {29'b0, done, busy, 1'b0} ordered [2]=done, [1]=busy, [0]=0; reserved -> 0; avs_readdata SHALL hold its value when not read.
REQ-017 START while idle SHALL copy DATA into a 32-bit shift register and latch REPEAT; busy and envelope SHALL rise on the next cycle; START while busy SHALL be ignored.
REQ-018 A unit timer SHALL count 0..UNIT_CYCLES-1 and restart at 0 on every state entry; each state lasts a whole number of units.
REQ-019 FSM states/durations (units): IDLE; LEAD_MARK 16; LEAD_SPACE 8 (4 if REPEAT); BIT_MARK 1; BIT_SPACE 1 for bit 0, 3 for bit 1; STOP_MARK 1; then IDLE.
REQ-020 Transitions: LEAD_SPACE -> BIT_MARK (data) or STOP_MARK (repeat); BIT_SPACE -> BIT_MARK until 32 bits sent, then STOP_MARK.
REQ-021 Bits SHALL be sent LSB first (DATA[0] first), matching the receiver's decoded word order.
REQ-022 coe_tx_env SHALL be 1 exactly in LEAD_MARK, BIT_MARK, STOP_MARK.
REQ-023 Carrier counter SHALL reset to 0 on each mark entry and wrap at CARRIER_DIV-1; coe_IRDA_TXD = env AND (count < CARRIER_HIGH); TXD SHALL be 0 in spaces and idle.
REQ-024 Done SHALL set on the cycle busy falls (STOP_MARK exit) and stay set until CLR_DONE.
REQ-025 CLR_DONE and START in one write: done SHALL clear and frame SHALL start.
REQ-026 Frame length: data = 24 + sum(2 per 0-bit, 4 per 1-bit) + 1 units; repeat = 16+4+1 = 21 units.

Reset
REQ-027 On csi_reset_n low, immediately: FSM IDLE, all counters 0, DATA 0, done 0, avs_readdata 0, coe_IRDA_TXD 0, coe_tx_env 0, coe_busy 0.
REQ-028 Reset mid-frame SHALL abort the frame with no further marks; operation resumes only on a new START.

Structure
REQ-029 Package ir_tx_pkg SHALL hold the FSM state enum, register address constants, CTRL bit indices and NEC unit counts (16, 8, 4, 1, 3).
REQ-030 Carrier generation SHALL be a sub-module ir_carrier_gen (inputs clk, reset, enable, restart; output carrier).

Verification (use UNIT_CYCLES=100, CARRIER_DIV=10, CARRIER_HIGH=3)
REQ-031 DATA=0x00000000, START -> busy for 89 units = 8900 cycles; 34 marks; done=1 after.
REQ-032 DATA=0xFFFFFFFF, START -> 153 units = 15300 cycles; every bit space 300 cycles.
REQ-033 DATA=0x5AA5F00F, START; decode env by space length -> 0x5AA5F00F LSB-first; TXD pulses 3 high/7 low within marks.
REQ-034 REPEAT+START -> mark 1600, space 400, mark 100 cycles; done=1; START during frame ignored.
REQ-035 Reset asserted in BIT_SPACE of bit 10 -> TXD/env/busy 0 same cycle, readback CTRL = 0.
REQ-036 Write CTRL=0x5 with done=1 -> done cleared, busy=1 next cycle; DATA write mid-frame leaves transmitted bits unchanged.
